// File: rtl/kun16_dm_arbiter.sv
// KUN16 data-memory arbiter: shares one single-port DM between core load/store and debug port.
// Latency: stores 1 cycle, loads return 1 cycle after issue (core sees exactly one stall cycle).
// Backpressure: core held via c_stall while pending/denied; debug holds its request until d_gnt.
// Optional starvation guard for the debug port enabled by defining KUN16_ARB_STARVE_GUARD_EN.
module kun16_dm_arbiter #(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_wen,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic [DW-1:0] c_rdata,
   output logic          c_stall,
   input  logic          d_req,
   input  logic          d_wen,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] m_addr,
   output logic          m_wen,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          owner
);

   typedef enum logic [0:0] {
      C_IDLE = 1'b0,
      C_DATA = 1'b1
   } c_state_t;

   c_state_t state, state_nxt;
   logic     core_want;
   logic     core_gnt;
   logic     dbg_gnt;
   logic     force_dbg;
   logic     rd_owner;   // 0: last load issued by core, 1: by debug

`ifdef KUN16_ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt;

   // Count consecutive cycles debug asks but is refused; saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!d_req || d_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != 4'hF) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign force_dbg = d_req && (starve_cnt == LIMIT);
`else
   logic [3:0] unused_limit;
   assign unused_limit = 4'(STARVE_LIMIT);
   assign force_dbg    = 1'b0;
`endif

   // Slot arbitration, core FSM next state and memory-port steering.
   always_comb begin
      core_want = c_req && (state == C_IDLE);
      core_gnt  = core_want && !force_dbg;
      dbg_gnt   = d_req && !core_gnt && rst;
      state_nxt = state;
      c_stall   = 1'b0;
      m_wen     = 1'b0;
      m_addr    = c_addr;
      m_wdata   = c_wdata;
      d_gnt     = 1'b0;
      owner     = 1'b0;
      case (state)
         C_IDLE: begin
            if (c_req) begin
               if (core_gnt && c_wen) begin
                  m_wen = 1'b1;
               end else if (core_gnt) begin
                  c_stall   = 1'b1;
                  state_nxt = C_DATA;
               end else begin
                  // denied by a forced debug slot: retry next cycle
                  c_stall = 1'b1;
               end
            end
         end
         C_DATA: begin
            // load data returns now; the slot itself is free for debug
            state_nxt = C_IDLE;
         end
         default: begin
            state_nxt = C_IDLE;
         end
      endcase
      if (dbg_gnt) begin
         d_gnt   = 1'b1;
         owner   = 1'b1;
         m_wen   = d_wen;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end
      if (!rst) begin
         m_wen   = 1'b0;
         c_stall = 1'b0;
         d_gnt   = 1'b0;
         owner   = 1'b0;
      end
   end

   // State register, debug read-valid pipeline and owner of the in-flight load.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= C_IDLE;
         d_rvalid <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         state    <= state_nxt;
         d_rvalid <= dbg_gnt && !d_wen;
         if (core_gnt && !c_wen) begin
            rd_owner <= 1'b0;
         end else if (dbg_gnt && !d_wen) begin
            rd_owner <= 1'b1;
         end
      end
   end

   // Returned read data is routed to exactly one requester, zero otherwise.
   assign c_rdata = ((state == C_DATA) && !rd_owner) ? m_rdata : '0;
   assign d_rdata = (d_rvalid && rd_owner) ? m_rdata : '0;

endmodule

// File: tb/tb_kun16_dm_arbiter.sv
// Bench for kun16_dm_arbiter: directed scenarios plus randomized traffic vs. a rule-level model.
// Includes a synchronous-read DM model (1-cycle latency, read-before-write).
// Starvation expectations follow KUN16_ARB_STARVE_GUARD_EN when defined.
module tb_kun16_dm_arbiter;

`ifdef KUN16_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req, c_wen;
   logic [15:0] c_addr, c_wdata, c_rdata;
   logic        c_stall;
   logic        d_req, d_wen;
   logic [15:0] d_addr, d_wdata, d_rdata;
   logic        d_gnt, d_rvalid;
   logic [15:0] m_addr, m_wdata, m_rdata;
   logic        m_wen;
   logic        owner;
   logic        mem_init;

   logic [15:0] mem    [0:255];
   logic [15:0] sh_mem [0:255];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   kun16_dm_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_stall(c_stall),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .owner(owner)
   );

   function automatic logic [15:0] init_val(input int a);
      return 16'(a * 4951) ^ 16'hC3A5;
   endfunction

   // DM macro model
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (m_wen) begin
         mem[m_addr[7:0]] <= m_wdata;
      end
      m_rdata <= mem[m_addr[7:0]];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_init = 1'b1;
      c_req = 0; c_wen = 0; c_addr = 0; c_wdata = 0;
      d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
      cyc(); cyc();
      c_req = 1; c_wen = 1; c_addr = 16'h0040; c_wdata = 16'h1111;
      d_req = 1; d_wen = 1; d_addr = 16'h0042; d_wdata = 16'h2222;
      smp();
      n_cmp++;
      if ({m_wen, d_gnt, c_stall, owner, d_rvalid} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_forced: m_wen,d_gnt,c_stall,owner,d_rvalid=%b want 00000",
                  {m_wen, d_gnt, c_stall, owner, d_rvalid});
      end
      cyc();
      c_req = 0; c_wen = 0; c_addr = 0; d_req = 0; d_wen = 0; d_addr = 0;
      rst = 1'b1; mem_init = 1'b0;
      smp();
      n_cmp++;
      if ({m_wen, d_gnt, c_stall, owner, d_rvalid} !== 5'b0 || m_addr !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_idle: flags=%b m_addr=%h want 00000 0000",
                  {m_wen, d_gnt, c_stall, owner, d_rvalid}, m_addr);
      end
      cyc();
   endtask

   task automatic test_core_store_load();
      c_req = 1; c_wen = 1; c_addr = 16'h0010; c_wdata = 16'hBEEF;
      smp();
      n_cmp++;
      if (m_wen !== 1'b1 || m_addr !== 16'h0010 || m_wdata !== 16'hBEEF || c_stall !== 1'b0) begin
         n_err++;
         $display("FAIL core_store: m_wen=%b m_addr=%h m_wdata=%h c_stall=%b want 1 0010 beef 0",
                  m_wen, m_addr, m_wdata, c_stall);
      end
      cyc();
      c_wen = 0; c_wdata = 0;
      smp();
      n_cmp++;
      if (c_stall !== 1'b1 || m_wen !== 1'b0 || m_addr !== 16'h0010) begin
         n_err++;
         $display("FAIL core_load_issue: c_stall=%b m_wen=%b m_addr=%h want 1 0 0010",
                  c_stall, m_wen, m_addr);
      end
      cyc();
      smp();
      n_cmp++;
      if (c_stall !== 1'b0 || c_rdata !== 16'hBEEF) begin
         n_err++;
         $display("FAIL core_load_data: c_stall=%b c_rdata=%h want 0 beef", c_stall, c_rdata);
      end
      cyc();
      c_req = 0;
      smp();
      n_cmp++;
      if (c_rdata !== 16'h0000) begin
         n_err++;
         $display("FAIL core_rdata_idle: c_rdata=%h want 0000", c_rdata);
      end
      cyc();
   endtask

   task automatic test_debug_burst();
      logic        eg, erv;
      logic [15:0] erd;
      for (int k = 0; k < 5; k++) begin
         d_req = (k < 3); d_wen = 0; d_addr = 16'(2 * k);
         eg  = (k < 3);
         erv = (k > 0) && (k < 4);
         erd = erv ? init_val(2 * (k - 1)) : 16'h0000;
         smp();
         n_cmp++;
         if (d_gnt !== eg || owner !== eg) begin
            n_err++;
            $display("FAIL dbg_burst_gnt[%0d]: d_gnt=%b owner=%b want %b", k, d_gnt, owner, eg);
         end
         n_cmp++;
         if (d_rvalid !== erv || d_rdata !== erd) begin
            n_err++;
            $display("FAIL dbg_burst_rdata[%0d]: d_rvalid=%b d_rdata=%h want %b %h",
                     k, d_rvalid, d_rdata, erv, erd);
         end
         cyc();
      end
      d_req = 0; d_addr = 0;
   endtask

   task automatic test_contention();
      c_req = 1; c_wen = 0; c_addr = 16'h0010;
      d_req = 1; d_wen = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
      smp();
      n_cmp++;
      if (d_gnt !== 1'b0 || c_stall !== 1'b1 || m_wen !== 1'b0 || m_addr !== 16'h0010 || owner !== 1'b0) begin
         n_err++;
         $display("FAIL contention_core_first: d_gnt=%b c_stall=%b m_wen=%b m_addr=%h owner=%b want 0 1 0 0010 0",
                  d_gnt, c_stall, m_wen, m_addr, owner);
      end
      cyc();
      smp();
      n_cmp++;
      if (d_gnt !== 1'b1 || m_wen !== 1'b1 || m_addr !== 16'h0020 || m_wdata !== 16'h1234 ||
          c_stall !== 1'b0 || c_rdata !== 16'hBEEF || owner !== 1'b1) begin
         n_err++;
         $display("FAIL contention_dbg_in_data: d_gnt=%b m_wen=%b m_addr=%h m_wdata=%h c_stall=%b c_rdata=%h owner=%b want 1 1 0020 1234 0 beef 1",
                  d_gnt, m_wen, m_addr, m_wdata, c_stall, c_rdata, owner);
      end
      cyc();
      c_req = 0; d_wen = 0;
      smp();
      n_cmp++;
      if (d_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL contention_readback_gnt: d_gnt=%b want 1", d_gnt);
      end
      cyc();
      d_req = 0;
      smp();
      n_cmp++;
      if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234) begin
         n_err++;
         $display("FAIL contention_readback: d_rvalid=%b d_rdata=%h want 1 1234", d_rvalid, d_rdata);
      end
      cyc();
   endtask

   task automatic test_starvation();
      logic        eg, erv;
      logic [15:0] erd;
      c_req = 1; c_wen = 1; c_addr = 16'h0030; c_wdata = 16'h7777;
      d_req = 1; d_wen = 0; d_addr = 16'h0010;
      for (int i = 1; i <= 7; i++) begin
         eg  = GUARD && (i == LIMIT + 1);
         erv = GUARD && (i == LIMIT + 2);
         erd = erv ? 16'hBEEF : 16'h0000;
         smp();
         n_cmp++;
         if (d_gnt !== eg || c_stall !== eg || m_wen !== !eg) begin
            n_err++;
            $display("FAIL starve_cycle[%0d]: d_gnt=%b c_stall=%b m_wen=%b want %b %b %b",
                     i, d_gnt, c_stall, m_wen, eg, eg, !eg);
         end
         n_cmp++;
         if (d_rvalid !== erv || d_rdata !== erd) begin
            n_err++;
            $display("FAIL starve_rdata[%0d]: d_rvalid=%b d_rdata=%h want %b %h",
                     i, d_rvalid, d_rdata, erv, erd);
         end
         cyc();
         if (GUARD && i >= LIMIT + 1) d_req = 0;
      end
      c_req = 0; d_req = 0;
      cyc(); cyc();
   endtask

   task automatic test_reset_mid_load();
      c_req = 1; c_wen = 0; c_addr = 16'h0010;
      smp();
      n_cmp++;
      if (c_stall !== 1'b1) begin
         n_err++;
         $display("FAIL rml_issue: c_stall=%b want 1", c_stall);
      end
      cyc();
      rst = 1'b0; d_req = 1; d_wen = 0; d_addr = 16'h0000;
      smp();
      n_cmp++;
      if (d_gnt !== 1'b0 || owner !== 1'b0 || c_stall !== 1'b0 || m_wen !== 1'b0) begin
         n_err++;
         $display("FAIL rml_during: d_gnt=%b owner=%b c_stall=%b m_wen=%b want 0 0 0 0",
                  d_gnt, owner, c_stall, m_wen);
      end
      cyc();
      rst = 1'b1; c_req = 0; d_req = 0;
      smp();
      n_cmp++;
      if (c_stall !== 1'b0 || d_rvalid !== 1'b0 || owner !== 1'b0 || c_rdata !== 16'h0000) begin
         n_err++;
         $display("FAIL rml_after: c_stall=%b d_rvalid=%b owner=%b c_rdata=%h want 0 0 0 0000",
                  c_stall, d_rvalid, owner, c_rdata);
      end
      cyc();
      c_req = 1; c_wen = 0; c_addr = 16'h0010;
      smp();
      n_cmp++;
      if (c_stall !== 1'b1 || d_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL rml_idle_restart: c_stall=%b d_rvalid=%b want 1 0", c_stall, d_rvalid);
      end
      cyc();
      smp();
      n_cmp++;
      if (c_stall !== 1'b0 || c_rdata !== 16'hBEEF) begin
         n_err++;
         $display("FAIL rml_reload: c_stall=%b c_rdata=%h want 0 beef", c_stall, c_rdata);
      end
      cyc();
      c_req = 0;
      cyc();
   endtask

   task automatic test_random();
      bit          c_wait = 0, d_pend = 0, c_hold = 0, d_hold = 0;
      logic [15:0] c_val = 0, d_val = 0;
      int          starve = 0;
      bit          cwin, dwin, e_st, e_mw;
      logic [15:0] e_ma, e_md, e_cr, e_dr;
      c_req = 0; d_req = 0; mem_init = 1;
      cyc();
      mem_init = 0;
      for (int a = 0; a < 256; a++) sh_mem[a] = init_val(a);
      cyc();
      for (int n = 0; n < 800; n++) begin
         if (!c_hold) begin
            c_req   = ($urandom_range(0, 2) != 0);
            c_wen   = 1'($urandom_range(0, 1));
            c_addr  = {8'h00, 8'($urandom_range(0, 31))};
            c_wdata = 16'($urandom);
         end
         if (!d_hold) begin
            d_req   = 1'($urandom_range(0, 1));
            d_wen   = 1'($urandom_range(0, 1));
            d_addr  = {8'h00, 8'($urandom_range(0, 31))};
            d_wdata = 16'($urandom);
         end
         // rule-level expectations for this cycle
         cwin = c_req && !c_wait && !(GUARD && d_req && starve == LIMIT);
         dwin = d_req && !cwin;
         e_st = !c_wait && c_req && !(cwin && c_wen);
         e_mw = cwin ? c_wen : (dwin ? d_wen : 1'b0);
         e_ma = dwin ? d_addr : c_addr;
         e_md = dwin ? d_wdata : c_wdata;
         e_cr = c_wait ? c_val : 16'h0000;
         e_dr = d_pend ? d_val : 16'h0000;
         smp();
         n_cmp++;
         if (c_stall !== e_st || d_gnt !== dwin || owner !== dwin) begin
            n_err++;
            $display("FAIL rnd_ctrl[%0d]: c_stall=%b d_gnt=%b owner=%b want %b %b %b",
                     n, c_stall, d_gnt, owner, e_st, dwin, dwin);
         end
         n_cmp++;
         if (m_wen !== e_mw || m_addr !== e_ma || m_wdata !== e_md) begin
            n_err++;
            $display("FAIL rnd_mem[%0d]: m_wen=%b m_addr=%h m_wdata=%h want %b %h %h",
                     n, m_wen, m_addr, m_wdata, e_mw, e_ma, e_md);
         end
         n_cmp++;
         if (c_rdata !== e_cr) begin
            n_err++;
            $display("FAIL rnd_crdata[%0d]: c_rdata=%h want %h", n, c_rdata, e_cr);
         end
         n_cmp++;
         if (d_rvalid !== d_pend || d_rdata !== e_dr) begin
            n_err++;
            $display("FAIL rnd_drdata[%0d]: d_rvalid=%b d_rdata=%h want %b %h",
                     n, d_rvalid, d_rdata, d_pend, e_dr);
         end
         // advance the model
         c_val  = sh_mem[c_addr[7:0]];
         d_val  = sh_mem[d_addr[7:0]];
         c_wait = cwin && !c_wen;
         d_pend = dwin && !d_wen;
         if (cwin && c_wen) sh_mem[c_addr[7:0]] = c_wdata;
         if (dwin && d_wen) sh_mem[d_addr[7:0]] = d_wdata;
         if (d_req && !dwin) starve = (starve < 15) ? starve + 1 : 15;
         else starve = 0;
         c_hold = e_st;
         d_hold = d_req && !dwin;
         cyc();
      end
      c_req = 0; d_req = 0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_core_store_load();
      test_debug_burst();
      test_contention();
      test_starvation();
      test_reset_mid_load();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
